// File: rtl/addsub_pipe_pkg.sv
// addsub_pipe_pkg: shared types and helpers for the pipelined adder/subtractor.
//   beat_ctl_t   - per-beat control bits that travel down the pipe with the data
//   sat_kind_e   - which saturation constant applies to an overflowing beat
//   cfg_legal()  - WIDTH/STAGES legality check used at elaboration
//   sat_kind()   - selects the saturation constant from the beat's mode bits
package addsub_pipe_pkg;

   typedef struct packed {
      logic sub;   // 1: a - b
      logic sgn;   // 1: signed overflow rules
      logic sat;   // 1: saturate on overflow
      logic amsb;  // MSB of operand a, picks the signed saturation direction
   } beat_ctl_t;

   typedef enum logic [1:0] {
      SAT_MAX_POS,  // 0x7F..F
      SAT_MIN_NEG,  // 0x80..0
      SAT_ONES,     // all ones
      SAT_ZERO      // all zeros
   } sat_kind_e;

   function automatic logic cfg_legal(input int unsigned width, input int unsigned stages);
      return (stages != 0) && (width >= stages) && ((width % stages) == 0);
   endfunction

   function automatic sat_kind_e sat_kind(input logic sgn, input logic sub, input logic amsb);
      if (sgn) return amsb ? SAT_MIN_NEG : SAT_MAX_POS;
      return sub ? SAT_ZERO : SAT_ONES;
   endfunction

endpackage

// File: rtl/addsub_stage.sv
// addsub_stage: one chunk of the carry-pipelined adder.
//   a_i, b_i  - chunk operands (b already inverted for subtraction)
//   c_i       - carry into the chunk
//   s_o       - chunk sum
//   c_o       - carry out of the chunk MSB
//   cmsb_o    - carry into the chunk MSB (used by the last chunk for signed overflow)
module addsub_stage #(
   parameter int unsigned CW = 8
) (
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          c_i,
   output logic [CW-1:0] s_o,
   output logic          c_o,
   output logic          cmsb_o
);

   always_comb begin
      {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
      // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
      cmsb_o     = a_i[CW-1] ^ b_i[CW-1] ^ s_o[CW-1];
   end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/subtract with valid/ready handshake on both sides,
// signed/unsigned overflow flags and optional saturation.
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - input handshake; a, b, sub, sgn, sat are the beat
//   out_valid/out_ready   - output handshake
//   s                     - result (saturated when sat=1 and overflow)
//   out_carry, out_ovf    - raw carry out of MSB, overflow per mode
//   out_zero              - s == 0 after saturation
// Stage i adds chunk i of WIDTH/STAGES bits; the last chunk is added and
// saturated straight into the output registers, giving a latency of STAGES.
// The whole pipe freezes while the output is stalled, so bubbles are kept.
module addsub_pipe
   import addsub_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sgn,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_zero
);

   if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
      $error("addsub_pipe: WIDTH (%0d) must be a non-zero multiple of STAGES (%0d)", WIDTH, STAGES);
   end

   localparam int unsigned CW   = (STAGES == 0) ? WIDTH : WIDTH / STAGES;
   localparam int unsigned LAST = (STAGES == 0) ? 0 : STAGES - 1;

   // pipe register i holds the beat whose chunk i is being added this cycle
   logic             v_q   [STAGES];
   logic             v_d   [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] a_d   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] b_d   [STAGES];
   logic [WIDTH-1:0] p_q   [STAGES];  // partial sum, chunks below i valid
   logic [WIDTH-1:0] p_d   [STAGES];
   logic             c_q   [STAGES];
   logic             c_d   [STAGES];
   beat_ctl_t        ctl_q [STAGES];
   beat_ctl_t        ctl_d [STAGES];

   logic [CW-1:0]    sum_w  [STAGES];
   logic             cout_w [STAGES];
   logic             cmsb_w [STAGES];

   logic             out_valid_q;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             stall;

   assign stall     = out_valid_q && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign out_carry = carry_q;
   assign out_ovf   = ovf_q;
   assign out_zero  = zero_q;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      addsub_stage #(.CW(CW)) u_stage (
         .a_i    (a_q[i][i*CW +: CW]),
         .b_i    (b_q[i][i*CW +: CW]),
         .c_i    (c_q[i]),
         .s_o    (sum_w[i]),
         .c_o    (cout_w[i]),
         .cmsb_o (cmsb_w[i])
      );
   end

   always_comb begin
      v_d[0]   = in_valid;
      a_d[0]   = a;
      b_d[0]   = sub ? ~b : b;
      p_d[0]   = '0;
      c_d[0]   = sub;  // the +1 of a + ~b + 1
      ctl_d[0] = '{sub: sub, sgn: sgn, sat: sat, amsb: a[WIDTH-1]};
      for (int unsigned i = 1; i < STAGES; i++) begin
         v_d[i]                  = v_q[i-1];
         a_d[i]                  = a_q[i-1];
         b_d[i]                  = b_q[i-1];
         p_d[i]                  = p_q[i-1];
         p_d[i][(i-1)*CW +: CW]  = sum_w[i-1];
         c_d[i]                  = cout_w[i-1];
         ctl_d[i]                = ctl_q[i-1];
      end
   end

   // final stage: assemble the full sum, derive flags, then saturate
   always_comb begin
      s_d                   = p_q[LAST];
      s_d[LAST*CW +: CW]    = sum_w[LAST];
      carry_d               = cout_w[LAST];
      if (ctl_q[LAST].sgn) ovf_d = cmsb_w[LAST] ^ cout_w[LAST];
      else                 ovf_d = ctl_q[LAST].sub ? !cout_w[LAST] : cout_w[LAST];
      if (ctl_q[LAST].sat && ovf_d) begin
         unique case (sat_kind(ctl_q[LAST].sgn, ctl_q[LAST].sub, ctl_q[LAST].amsb))
            SAT_MAX_POS: s_d = {1'b0, {(WIDTH-1){1'b1}}};
            SAT_MIN_NEG: s_d = {1'b1, {(WIDTH-1){1'b0}}};
            SAT_ONES:    s_d = '1;
            default:     s_d = '0;
         endcase
      end
      zero_d = (s_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) v_q[i] <= 1'b0;
         out_valid_q <= 1'b0;
         s_q         <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else if (!stall) begin
         v_q         <= v_d;
         out_valid_q <= v_q[LAST];
         if (v_q[LAST]) begin
            s_q     <= s_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
         end
      end
   end

   // payload registers need no reset: their valid bits gate them
   always_ff @(posedge clk) begin
      if (!stall) begin
         a_q   <= a_d;
         b_q   <= b_d;
         p_q   <= p_d;
         c_q   <= c_d;
         ctl_q <= ctl_d;
      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        sub, sgn, sat;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s;
   logic        out_carry, out_ovf, out_zero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   addsub_pipe #(.WIDTH(32), .STAGES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .sgn       (sgn),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one isolated beat: checks latency and every result field
   task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vsub, input logic vsgn, input logic vsat,
                          input logic [31:0] es, input logic ec, input logic eo, input logic ez);
      int lat;
      @(posedge clk); #1;
      in_valid = 1'b1; a = va; b = vb; sub = vsub; sgn = vsgn; sat = vsat;
      #1;
      check({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; a = '1; b = '1; sub = ~vsub; sgn = ~vsgn; sat = ~vsat;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_s"},     s,         es);
      check({tag, "_carry"}, out_carry, ec);
      check({tag, "_ovf"},   out_ovf,   eo);
      check({tag, "_zero"},  out_zero,  ez);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] sa [8];
      logic [31:0] sb [8];
      logic [31:0] se [8];
      int sent, recv, stall_left, stall_cycles, extra;
      logic stalled;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0; sgn = 1'b0; sat = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_s",         s,         32'h0);
      check("rst_carry",     out_carry, 1'b0);
      check("rst_ovf",       out_ovf,   1'b0);
      check("rst_zero",      out_zero,  1'b0);
      check("rst_in_ready",  in_ready,  1'b1);

      //       tag          a             b             sub   sgn   sat   s             c     o     z
      run_vec("s_wrap",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      run_vec("s_sat",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
      run_vec("u_sub",    32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
      run_vec("u_subsat", 32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1);
      run_vec("chunk_c",  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
      run_vec("full_c",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
      run_vec("s_negsat", 32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
      run_vec("u_addsat", 32'hFFFFFFF0, 32'h00000020, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
      run_vec("s_subeq",  32'h00000005, 32'h00000005, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);

      // back-to-back stream with a 3-cycle output stall mid-stream
      for (int i = 0; i < 8; i++) begin
         sa[i] = 32'h11111111 * (i + 1);
         sb[i] = 32'h0F0F0F0F + i;
         se[i] = sa[i] + sb[i];
      end
      sub = 1'b0; sgn = 1'b0; sat = 1'b0;
      sent = 0; recv = 0; stall_left = 0; stall_cycles = 0; stalled = 1'b0;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         @(posedge clk); #1;
         if (recv == 3 && !stalled) begin
            stall_left = 3;
            stalled    = 1'b1;
         end
         out_ready = (stall_left == 0);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            a = sa[sent];
            b = sb[sent];
         end
         #1;
         check("stream_in_ready", in_ready, (stall_left == 0));
         if (stall_left != 0) begin
            stall_cycles++;
            check("stall_valid_held", out_valid, 1'b1);
            check("stall_s_held",     s,         se[recv]);
            stall_left--;
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            check("stream_s", s, se[recv]);
            recv++;
         end
      end
      check("stream_stall_cycles", stall_cycles, 3);
      check("stream_sent", sent, 8);
      check("stream_recv", recv, 8);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (out_valid) extra++;
         @(posedge clk); #1;
      end
      check("stream_no_dup", extra, 0);

      // reset with three beats in flight and a fourth offered in the reset cycle
      @(posedge clk); #1;
      in_valid = 1'b1; a = 32'h00000100; b = 32'h00000001;
      @(posedge clk); #1;
      a = 32'h00000200;
      @(posedge clk); #1;
      a = 32'h00000300;
      @(posedge clk); #1;
      rst = 1'b1; a = 32'h00000400;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_s",         s,         32'h0);
      check("midrst_in_ready",  in_ready,  1'b1);
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) extra++;
      end
      check("midrst_no_ghost", extra, 0);

      run_vec("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
